// File: rtl/mips_controller.sv
// Multicycle MIPS subset controller: Moore FSM sequencing fetch (4 byte loads),
// decode and execute phases, plus combinational ALU control decode and PC enable.
module mips_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       memread,
   output logic       memwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucont,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic [3:0] irwrite,
   output logic [1:0] pcsource,
   output logic       pcen
);

   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
      SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
   } state_t;

   state_t     state_q, state_d;
   logic       pcwrite, branch;
   logic       memwrite_s, regwrite_s;
   logic [3:0] irwrite_s;
   logic [1:0] aluop;

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH1;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH1;
      case (state_q)
         FETCH1:  state_d = FETCH2;
         FETCH2:  state_d = FETCH3;
         FETCH3:  state_d = FETCH4;
         FETCH4:  state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LB, OP_SB: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_J:         state_d = JEX;
               OP_ADDI:      state_d = ADDIEX;
               default:      state_d = FETCH1;
            endcase
         end
         // Only LB/SB reach here; anything else falls back to fetch.
         MEMADR:  state_d = (op == OP_LB) ? LBRD : ((op == OP_SB) ? SBWR : FETCH1);
         LBRD:    state_d = LBWR;
         RTYPEEX: state_d = RTYPEWR;
         ADDIEX:  state_d = ADDIWR;
         default: state_d = FETCH1;
      endcase
   end

   always_comb begin
      memread    = 1'b0;
      memwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      regwrite_s = 1'b0;
      irwrite_s  = 4'b0000;
      pcsource   = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      case (state_q)
         FETCH1, FETCH2, FETCH3, FETCH4: begin
            memread   = 1'b1;
            alusrcb   = 2'b01;
            pcwrite   = 1'b1;
            irwrite_s = 4'b0001 << state_q[1:0];
         end
         DECODE:  alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         LBRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         LBWR: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
         end
         SBWR: begin
            memwrite_s = 1'b1;
            iord       = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWR: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
         end
         BEQEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            branch   = 1'b1;
            pcsource = 2'b01;
         end
         JEX: begin
            pcwrite  = 1'b1;
            pcsource = 2'b10;
         end
         ADDIWR:  regwrite_s = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      alucont = 3'b010;
      case (aluop)
         2'b01: alucont = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: alucont = 3'b110;
               6'b100100: alucont = 3'b000;
               6'b100101: alucont = 3'b001;
               6'b101010: alucont = 3'b111;
               default:   alucont = 3'b010;
            endcase
         end
         default: alucont = 3'b010;
      endcase
   end

   // State-changing strobes are suppressed while reset is held.
   assign memwrite = memwrite_s & ~reset;
   assign regwrite = regwrite_s & ~reset;
   assign irwrite  = reset ? 4'b0000 : irwrite_s;
   assign pcen     = (pcwrite | (branch & zero)) & ~reset;

endmodule

// File: tb/tb_mips_controller.sv
// Randomized scoreboard bench for mips_controller: per-cycle expected outputs
// are derived from instruction phase lists and checked by a separate monitor.
module tb_mips_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
   logic [1:0] alusrcb, pcsource;
   logic [2:0] alucont;
   logic [3:0] irwrite;

   mips_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucont(alucont), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
      .regwrite(regwrite), .irwrite(irwrite), .pcsource(pcsource), .pcen(pcen)
   );

   always #5 clk = ~clk;

   typedef enum int {
      P_F1, P_F2, P_F3, P_F4, P_DEC, P_MEM, P_LBRD, P_LBWR, P_SBWR,
      P_REX, P_RWR, P_BEQ, P_JEX, P_AEX, P_AWR
   } ph_e;

   typedef struct packed {
      logic       memread, memwrite, alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucont;
      logic       iord, memtoreg, regdst, regwrite;
      logic [3:0] irwrite;
      logic [1:0] pcsource;
      logic       pcen;
   } out_t;

   typedef struct {
      out_t exp;
      ph_e  ph;
   } item_t;

   item_t exp_q[$];
   int checks = 0;
   int failures = 0;

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic out_t model(input ph_e ph, input logic [5:0] f, input logic z, input logic r);
      out_t o;
      logic pcw, br;
      o = '0;
      o.alucont = 3'b010;
      pcw = 1'b0;
      br  = 1'b0;
      case (ph)
         P_F1, P_F2, P_F3, P_F4: begin
            o.memread = 1; o.alusrcb = 2'b01; pcw = 1;
            o.irwrite = 4'(1 << (int'(ph) - int'(P_F1)));
         end
         P_DEC:  o.alusrcb = 2'b11;
         P_MEM, P_AEX: begin o.alusrca = 1; o.alusrcb = 2'b10; end
         P_LBRD: begin o.memread = 1; o.iord = 1; end
         P_LBWR: begin o.regwrite = 1; o.memtoreg = 1; end
         P_SBWR: begin o.memwrite = 1; o.iord = 1; end
         P_REX:  begin o.alusrca = 1; o.alucont = funct_alu(f); end
         P_RWR:  begin o.regwrite = 1; o.regdst = 1; end
         P_BEQ:  begin o.alusrca = 1; o.alucont = 3'b110; br = 1; o.pcsource = 2'b01; end
         P_JEX:  begin pcw = 1; o.pcsource = 2'b10; end
         P_AWR:  o.regwrite = 1;
         default: ;
      endcase
      o.pcen = pcw | (br & z);
      if (r) begin
         o.memwrite = 0; o.regwrite = 0; o.pcen = 0; o.irwrite = 4'b0000;
      end
      return o;
   endfunction

   task automatic step(input ph_e ph, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r);
      item_t it;
      @(posedge clk);
      #1;
      op = o; funct = f; zero = z; reset = r;
      it.exp = model(ph, f, z, r);
      it.ph  = ph;
      exp_q.push_back(it);
   endtask

   // zsel: 0/1 forces zero, 2 randomizes it; abort_at asserts reset at that phase index.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel, input int abort_at);
      ph_e seq[$];
      logic [5:0] oo, ff;
      logic z, r;
      seq.push_back(P_F1); seq.push_back(P_F2); seq.push_back(P_F3);
      seq.push_back(P_F4); seq.push_back(P_DEC);
      case (o)
         6'b100000: begin seq.push_back(P_MEM); seq.push_back(P_LBRD); seq.push_back(P_LBWR); end
         6'b101000: begin seq.push_back(P_MEM); seq.push_back(P_SBWR); end
         6'b000000: begin seq.push_back(P_REX); seq.push_back(P_RWR); end
         6'b000100: seq.push_back(P_BEQ);
         6'b000010: seq.push_back(P_JEX);
         6'b001000: begin seq.push_back(P_AEX); seq.push_back(P_AWR); end
         default: ;
      endcase
      for (int i = 0; i < seq.size(); i++) begin
         oo = (seq[i] inside {P_DEC, P_MEM, P_REX}) ? o : 6'($urandom);
         ff = (seq[i] == P_REX) ? f : 6'($urandom);
         z  = (zsel == 2) ? 1'($urandom) : zsel[0];
         r  = (i == abort_at);
         step(seq[i], oo, ff, z, r);
         if (r) break;
      end
   endtask

   always @(negedge clk) begin
      item_t it;
      out_t act;
      if (exp_q.size() > 0) begin
         it = exp_q.pop_front();
         act = '{memread, memwrite, alusrca, alusrcb, alucont, iord, memtoreg,
                 regdst, regwrite, irwrite, pcsource, pcen};
         checks++;
         if (act !== it.exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", it.ph.name(), act, it.exp);
         end
      end
   end

   logic [5:0] ops[7];
   logic [5:0] fns[6];

   initial begin
      ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
      reset = 1; op = 0; funct = 0; zero = 0;
      @(posedge clk);
      step(P_F1, 6'b000000, 6'b000000, 1'b1, 1'b1);

      run_instr(6'b000000, 6'b100010, 2, -1);
      run_instr(6'b100000, 6'b000000, 2, -1);
      run_instr(6'b000100, 6'b000000, 1, -1);
      run_instr(6'b000100, 6'b000000, 0, -1);
      run_instr(6'b000010, 6'b000000, 2, -1);
      run_instr(6'b111111, 6'b000000, 2, -1);
      run_instr(6'b101000, 6'b000000, 2, 6);
      run_instr(6'b001000, 6'b000000, 2, -1);
      run_instr(6'b000000, 6'b100100, 2, -1);
      run_instr(6'b000000, 6'b100101, 2, -1);
      run_instr(6'b000000, 6'b101010, 2, -1);
      run_instr(6'b000000, 6'b000000, 2, -1);

      for (int n = 0; n < 300; n++) begin
         logic [5:0] o, f;
         int ab;
         o  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
         run_instr(o, f, 2, ab);
      end

      for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
